mem_agen_queue: RTL and testbench
=================================

# mem_agen_queue

Multi-lane address-generation stage for the memory pipe, generalising the single-lane combinational AGEN into `LANES` parallel AGEN units feeding an in-order `DEPTH`-entry queue toward the LSQ. Sits between the memory-pipe register read/bypass stage and the LSQ. Source operands arrive already bypass-resolved. The block adds the following over the single-lane stage:

- backpressure;
- misalignment detection;
- byte-enable generation;
- flush on recovery.

## Interface
- `LANES`, default 2: parallel memory instructions accepted per cycle (≥1).
- `DEPTH`, default 4: queue entries (≥`LANES`; need not be a power of two).
- `IMM_W`, default 16: immediate width, sign-extended.
- `TAG_W`, default 24: opaque tag (packed phyDest/alID/lsqID), passed through unchanged.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  recovery flush; discards all queued and incoming entries.
- `in_valid_i`  in  LANES  per-lane instruction valid.
- `in_src1_i`  in  LANES×32  base register value.
- `in_src2_i`  in  LANES×32  store data.
- `in_imm_i`  in  LANES×IMM_W  offset.
- `in_size_i`  in  LANES×2  access size: 0=byte, 1=half, 2=word, 3=illegal.
- `in_store_i`  in  LANES  1=store, 0=load.
- `in_tag_i`  in  LANES×TAG_W  tag.
- `in_ready_o`  out  1  group accept: the whole lane group is taken this cycle.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  LSQ accepts head.
- `out_addr_o`  out  32  effective address.
- `out_data_o`  out  32  store data shifted to byte lane `addr[1:0]`.
- `out_be_o`  out  4  byte enables.
- `out_size_o`  out  2  size.
- `out_store_o`  out  1  store flag.
- `out_misalign_o`  out  1  exception flag.
- `out_tag_o`  out  TAG_W  tag.
- `count_o`  out  clog2(DEPTH+1)  occupancy.

## Operation

**Address and data computation**
- Per-lane AGEN, combinational: `addr = src1 + sext(imm)`, modulo 2^32, carry discarded.
- Base byte-enable `be0`: size 0 → 0001, size 1 → 0011, size 2 → 1111, size 3 → 0000.
- `be = (be0 << addr[1:0])` truncated to 4 bits.
- `data = src2 << (8*addr[1:0])` truncated to 32 bits. Computed for loads as well; the LSQ ignores it.
- `misalign` is set when any of the following holds:
  - size 1 and `addr[0]` = 1;
  - size 2 and `addr[1:0]` ≠ 0;
  - size 3.
- Misaligned entries are still enqueued with the flag set. The exception is taken at retire.

**Enqueue**
- `in_ready_o = (DEPTH − count) ≥ LANES`, using the registered count only. A same-cycle dequeue does not create space.
- On `in_ready_o & !flush_i`, every lane with `in_valid_i` set is written, in ascending lane order, into consecutive entries starting at the tail.
- Invalid lanes are compacted out. Example: lanes {0 invalid, 1 valid} produce one entry.
- If `in_ready_o` = 0, the upstream holds all lanes.

**Dequeue**
- The head is presented when `count` > 0.
- Head pops on `out_valid_o & out_ready_i`.

**Pointers and occupancy**
- Head and tail pointers wrap from `DEPTH−1` to 0 explicitly.
- `count_next = count + nEnq − deq`.
- Simultaneous enqueue and dequeue are both honoured.

**Flush**
- Priority is flush > enqueue/dequeue.
- Next state: head = tail = count = 0.
- Lanes presented in the flush cycle are dropped.
- The head is not considered consumed, even if `out_ready_i` = 1.

**Reset**
- Asynchronous; takes effect immediately.
- Pointers, count and all entry storage are cleared to 0.
- `out_valid_o` = 0 and all `out_*` data fields = 0.
- `in_ready_o` is forced to 0 while `reset` is low, and returns to 1 in the first cycle after deassertion.
- Reset asserted mid-operation discards all contents; nothing is delivered afterwards.

## Timing
- **Latency:** an entry accepted at edge N is visible on `out_*` in cycle N+1. There is no combinational input→output path.
- **Throughput:** up to `LANES` entries in, 1 entry out per cycle.
- **Head outputs:** driven directly from registered storage indexed by head; `out_*` stays stable while `out_valid_o & !out_ready_i`.
- **`in_ready_o`:** combinational from registered count only; it does not depend on `out_ready_i`.
- **Full and empty:** full (`count` = DEPTH) blocks `in_ready_o`. Empty drives `out_valid_o` = 0, and `out_ready_i` is ignored.

## Test plan
- **Basic AGEN.** `LANES`=2, `DEPTH`=4. Lane0: src1=0x1000, imm=0xFFFC (−4), size 2, load. Lane1: src1=0x2001, imm=1, size 1, store, src2=0x0000ABCD. Expected response:
  - cycle +1: addr 0x0FFC, be 1111, misalign 0;
  - next pop: addr 0x2002, be 1100, data 0xABCD0000, misalign 0.
- **Misalignment and wrap.** Size 2 at addr 0x3 → misalign 1, be 1000. Size 3 → misalign 1, be 0000. src1=0xFFFFFFFF, imm=2 → addr 0x00000001.
- **Backpressure and full.** Hold `out_ready_i`=0 and enqueue 2+2 → `count_o`=4 and `in_ready_o`=0. Set `out_ready_i`=1 for one cycle → `count_o`=3 and `in_ready_o` still 0. A second pop → `in_ready_o`=1. Order is preserved across pointer wrap over 3 full fill/drain rounds.
- **Compaction.** Lane0 invalid, lane1 valid with tag 0x55 → `count_o`=1 and the head tag is 0x55. Simultaneous 2 enqueues + 1 dequeue at `count`=1 → `count_o`=2.
- **Flush.** Queue holds 3 entries and `flush_i`=1 with valid lanes and `out_ready_i`=1 → next cycle `count_o`=0 and `out_valid_o`=0. No flushed tag ever appears on the output.
- **Async reset.** Drop `reset` mid-cycle with 2 entries queued → outputs go to 0 immediately with no clock edge. After release, `in_ready_o`=1 and the queue is empty.

Source files
------------

// File: rtl/mem_agen_queue.sv
// Purpose: LANES parallel address-generation units feeding an in-order DEPTH-entry queue toward the LSQ.
// Latency: an entry accepted at edge N is on out_* in cycle N+1; there is no combinational input-to-output path.
// Backpressure: in_ready_o needs LANES free slots by registered count only; the head is held until out_ready_i.
module mem_agen_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 4,
  parameter int IMM_W = 16,
  parameter int TAG_W = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush_i,
  input  logic [LANES-1:0]            in_valid_i,
  input  logic [LANES-1:0][31:0]      in_src1_i,
  input  logic [LANES-1:0][31:0]      in_src2_i,
  input  logic [LANES-1:0][IMM_W-1:0] in_imm_i,
  input  logic [LANES-1:0][1:0]       in_size_i,
  input  logic [LANES-1:0]            in_store_i,
  input  logic [LANES-1:0][TAG_W-1:0] in_tag_i,
  output logic                        in_ready_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [31:0]                 out_addr_o,
  output logic [31:0]                 out_data_o,
  output logic [3:0]                  out_be_o,
  output logic [1:0]                  out_size_o,
  output logic                        out_store_o,
  output logic                        out_misalign_o,
  output logic [TAG_W-1:0]            out_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Slot arithmetic is done one bit wider so tail + offset can exceed DEPTH before wrapping.
  localparam int IW = ((PW > CW) ? PW : CW) + 1;

  typedef struct packed {
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [3:0]       be;
    logic [1:0]       size;
    logic             store;
    logic             misalign;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t        entries [DEPTH];
  entry_t        laneEntry [LANES];
  entry_t        headEntry;
  logic [31:0]   laneAddr [LANES];
  logic [3:0]    laneBe0 [LANES];
  logic [IW-1:0] wrapIdx [LANES];
  logic [IW-1:0] tailSum;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] nEnq;
  logic [CW-1:0] enqCnt;
  logic          enq;
  logic          deq;

  // Per-lane AGEN: effective address, shifted byte enables and store data, misalignment.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      laneAddr[i] = in_src1_i[i] + 32'(signed'(in_imm_i[i]));
      case (in_size_i[i])
        2'd0:    laneBe0[i] = 4'b0001;
        2'd1:    laneBe0[i] = 4'b0011;
        2'd2:    laneBe0[i] = 4'b1111;
        default: laneBe0[i] = 4'b0000;
      endcase
      laneEntry[i].addr     = laneAddr[i];
      laneEntry[i].data     = in_src2_i[i] << {laneAddr[i][1:0], 3'b000};
      laneEntry[i].be       = laneBe0[i] << laneAddr[i][1:0];
      laneEntry[i].size     = in_size_i[i];
      laneEntry[i].store    = in_store_i[i];
      laneEntry[i].misalign = (in_size_i[i] == 2'd3) ||
                              ((in_size_i[i] == 2'd2) && (laneAddr[i][1:0] != 2'b00)) ||
                              ((in_size_i[i] == 2'd1) && laneAddr[i][0]);
      laneEntry[i].tag      = in_tag_i[i];
    end
  end

  // Compaction: each valid lane lands at tail plus the number of valid lanes below it, wrapped.
  always_comb begin
    nEnq = '0;
    for (int i = 0; i < LANES; i++) begin
      wrapIdx[i] = IW'(tail) + IW'(nEnq);
      if (wrapIdx[i] >= IW'(DEPTH)) wrapIdx[i] = wrapIdx[i] - IW'(DEPTH);
      if (in_valid_i[i]) nEnq = nEnq + CW'(1);
    end
    tailSum = IW'(tail) + IW'(nEnq);
    if (tailSum >= IW'(DEPTH)) tailSum = tailSum - IW'(DEPTH);
  end

  // Space is judged on the registered count alone so a same-cycle pop never opens room.
  assign in_ready_o  = reset && ((DEPTH - int'(count)) >= LANES);
  assign out_valid_o = (count != '0);
  assign enq         = in_ready_o && !flush_i;
  assign deq         = out_valid_o && out_ready_i && !flush_i;
  assign enqCnt      = enq ? nEnq : '0;

  // Pointer and occupancy update; flush overrides both enqueue and dequeue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq) head <= (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);
      if (enq) tail <= PW'(tailSum);
      count <= count + enqCnt - CW'(deq);
    end
  end

  // Entry storage: write every valid lane into its compacted slot; reset clears all entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int e = 0; e < DEPTH; e++) entries[e] <= '0;
    end else if (enq) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_valid_i[i]) entries[PW'(wrapIdx[i])] <= laneEntry[i];
      end
    end
  end

  // Head fields come straight from storage, so they hold steady while stalled.
  assign headEntry      = entries[head];
  assign out_addr_o     = headEntry.addr;
  assign out_data_o     = headEntry.data;
  assign out_be_o       = headEntry.be;
  assign out_size_o     = headEntry.size;
  assign out_store_o    = headEntry.store;
  assign out_misalign_o = headEntry.misalign;
  assign out_tag_o      = headEntry.tag;
  assign count_o        = count;
endmodule

// File: tb/tb_mem_agen_queue.sv
// Bench for mem_agen_queue (LANES=2, DEPTH=4): directed scenarios plus random traffic.
// Expected entries are modelled on accept and compared at the head every cycle.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_agen_queue;
  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [1:0]       inValid;
  logic [1:0][31:0] inSrc1;
  logic [1:0][31:0] inSrc2;
  logic [1:0][15:0] inImm;
  logic [1:0][1:0]  inSize;
  logic [1:0]       inStore;
  logic [1:0][23:0] inTag;
  logic             inReady;
  logic             outValid;
  logic             outReady;
  logic [31:0]      outAddr;
  logic [31:0]      outData;
  logic [3:0]       outBe;
  logic [1:0]       outSize;
  logic             outStore;
  logic             outMis;
  logic [23:0]      outTag;
  logic [2:0]       count;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [1:0]  size;
    logic        store;
    logic        mis;
    logic [23:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_agen_queue #(.LANES(2), .DEPTH(4), .IMM_W(16), .TAG_W(24)) dut (
    .clk(clk), .reset(reset), .flush_i(flush),
    .in_valid_i(inValid), .in_src1_i(inSrc1), .in_src2_i(inSrc2), .in_imm_i(inImm),
    .in_size_i(inSize), .in_store_i(inStore), .in_tag_i(inTag), .in_ready_o(inReady),
    .out_valid_o(outValid), .out_ready_i(outReady), .out_addr_o(outAddr),
    .out_data_o(outData), .out_be_o(outBe), .out_size_o(outSize), .out_store_o(outStore),
    .out_misalign_o(outMis), .out_tag_o(outTag), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: byte-lane placement written out per offset.
  function automatic exp_t model(input logic [31:0] s1, input logic [31:0] s2, input logic [15:0] imm,
                                 input logic [1:0] sz, input logic st, input logic [23:0] tg);
    exp_t       e;
    logic [3:0] be0;
    e.addr = s1 + {{16{imm[15]}}, imm};
    case (sz)
      2'd0:    be0 = 4'b0001;
      2'd1:    be0 = 4'b0011;
      2'd2:    be0 = 4'b1111;
      default: be0 = 4'b0000;
    endcase
    case (e.addr[1:0])
      2'd0:    begin e.be = be0;               e.data = s2;                 end
      2'd1:    begin e.be = {be0[2:0], 1'b0};  e.data = {s2[23:0], 8'h0};   end
      2'd2:    begin e.be = {be0[1:0], 2'b00}; e.data = {s2[15:0], 16'h0};  end
      default: begin e.be = {be0[0], 3'b000};  e.data = {s2[7:0], 24'h0};   end
    endcase
    e.mis   = (sz == 2'd3) || (sz == 2'd2 && e.addr[1:0] != 2'd0) || (sz == 2'd1 && e.addr[0]);
    e.size  = sz;
    e.store = st;
    e.tag   = tg;
    return e;
  endfunction

  task automatic clearLanes();
    inValid = '0; inSrc1 = '0; inSrc2 = '0; inImm = '0; inSize = '0; inStore = '0; inTag = '0;
  endtask

  task automatic setLane(input int l, input logic [31:0] s1, input logic [31:0] s2, input logic [15:0] imm,
                         input logic [1:0] sz, input logic st, input logic [23:0] tg);
    inValid[l] = 1'b1; inSrc1[l] = s1; inSrc2[l] = s2; inImm[l] = imm;
    inSize[l] = sz; inStore[l] = st; inTag[l] = tg;
  endtask

  task automatic randLane(input int l, input logic [23:0] tg);
    setLane(l, $urandom, $urandom, 16'($urandom), 2'($urandom), 1'($urandom), tg);
  endtask

  // One clock: compare DUT against the scoreboard, then apply the cycle's effect to the model.
  task automatic tick();
    bit acc;
    bit pop;
    exp_t e;
    @(negedge clk);
    checkVal("count", 64'(count), 64'(sb.size()));
    checkVal("in_ready", 64'(inReady), 64'((4 - sb.size()) >= 2));
    checkVal("out_valid", 64'(outValid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      e = sb[0];
      checkVal("head_addr", outAddr, e.addr);
      checkVal("head_data", outData, e.data);
      checkVal("head_be", 64'(outBe), 64'(e.be));
      checkVal("head_size", 64'(outSize), 64'(e.size));
      checkVal("head_store", 64'(outStore), 64'(e.store));
      checkVal("head_mis", 64'(outMis), 64'(e.mis));
      checkVal("head_tag", 64'(outTag), 64'(e.tag));
    end
    acc = ((4 - sb.size()) >= 2) && !flush;
    pop = (sb.size() != 0) && outReady && !flush;
    @(posedge clk);
    #1;
    if (flush) begin
      sb.delete();
    end else begin
      if (pop) void'(sb.pop_front());
      if (acc) begin
        for (int l = 0; l < 2; l++)
          if (inValid[l]) sb.push_back(model(inSrc1[l], inSrc2[l], inImm[l], inSize[l], inStore[l], inTag[l]));
      end
    end
  endtask

  task automatic drain();
    clearLanes();
    outReady = 1'b1;
    for (int k = 0; k < 8 && sb.size() != 0; k++) tick();
    checkVal("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; outReady = 1'b0;
    clearLanes();
    #3;
    checkVal("rst_in_ready", 64'(inReady), 64'd0);
    checkVal("rst_out_valid", 64'(outValid), 64'd0);
    checkVal("rst_count", 64'(count), 64'd0);
    checkVal("rst_addr", outAddr, 64'd0);
    checkVal("rst_tag", 64'(outTag), 64'd0);
    #19 reset = 1'b1;
    #1;
    checkVal("rel_in_ready", 64'(inReady), 64'd1);
    @(posedge clk);
    #1;

    // Basic AGEN: negative offset word load and an odd-base halfword store.
    setLane(0, 32'h1000, 32'h0, 16'hFFFC, 2'd2, 1'b0, 24'h000011);
    setLane(1, 32'h2001, 32'h0000ABCD, 16'h0001, 2'd1, 1'b1, 24'h000022);
    tick();
    clearLanes();
    checkVal("basic0_addr", outAddr, 64'h0FFC);
    checkVal("basic0_be", 64'(outBe), 64'hF);
    checkVal("basic0_mis", 64'(outMis), 64'd0);
    checkVal("basic_count", 64'(count), 64'd2);
    outReady = 1'b1;
    tick();
    checkVal("basic1_addr", outAddr, 64'h2002);
    checkVal("basic1_be", 64'(outBe), 64'hC);
    checkVal("basic1_data", outData, 64'hABCD0000);
    checkVal("basic1_mis", 64'(outMis), 64'd0);
    tick();

    // Misalignment and 32-bit address wrap.
    setLane(0, 32'h3, 32'h11223344, 16'h0, 2'd2, 1'b1, 24'h000031);
    setLane(1, 32'h10, 32'h0, 16'h0, 2'd3, 1'b0, 24'h000032);
    tick();
    clearLanes();
    checkVal("mis_word_flag", 64'(outMis), 64'd1);
    checkVal("mis_word_be", 64'(outBe), 64'h8);
    checkVal("mis_word_data", outData, 64'h44000000);
    tick();
    checkVal("mis_ill_flag", 64'(outMis), 64'd1);
    checkVal("mis_ill_be", 64'(outBe), 64'h0);
    setLane(0, 32'hFFFFFFFF, 32'h0, 16'h0002, 2'd0, 1'b0, 24'h000033);
    tick();
    clearLanes();
    checkVal("wrap_addr", outAddr, 64'h1);
    checkVal("wrap_be", 64'(outBe), 64'h2);
    drain();

    // Backpressure to full, then pops; group stays presented while blocked.
    outReady = 1'b0;
    randLane(0, 24'h000041); randLane(1, 24'h000042);
    tick();
    randLane(0, 24'h000043); randLane(1, 24'h000044);
    tick();
    checkVal("full_count", 64'(count), 64'd4);
    checkVal("full_in_ready", 64'(inReady), 64'd0);
    outReady = 1'b1;
    tick();
    checkVal("pop1_count", 64'(count), 64'd3);
    checkVal("pop1_in_ready", 64'(inReady), 64'd0);
    tick();
    checkVal("pop2_in_ready", 64'(inReady), 64'd1);
    drain();
    for (int r = 0; r < 3; r++) begin
      outReady = 1'b0;
      for (int k = 0; k < 2; k++) begin
        randLane(0, 24'(24'h000100 + r * 16 + k * 2));
        randLane(1, 24'(24'h000101 + r * 16 + k * 2));
        tick();
      end
      clearLanes();
      outReady = 1'b1;
      repeat (4) tick();
      checkVal("round_count", 64'(count), 64'd0);
    end

    // Compaction of an invalid lane 0, then 2 enqueues with 1 dequeue.
    outReady = 1'b0;
    clearLanes();
    randLane(1, 24'h000055);
    tick();
    clearLanes();
    checkVal("compact_count", 64'(count), 64'd1);
    checkVal("compact_tag", 64'(outTag), 64'h55);
    randLane(0, 24'h000056); randLane(1, 24'h000057);
    outReady = 1'b1;
    tick();
    clearLanes();
    checkVal("enq2_deq1_count", 64'(count), 64'd2);

    // Flush with 3 queued, valid lanes and a ready LSQ.
    outReady = 1'b0;
    randLane(0, 24'h000066);
    tick();
    clearLanes();
    checkVal("preflush_count", 64'(count), 64'd3);
    randLane(0, 24'h00BAD1); randLane(1, 24'h00BAD2);
    outReady = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clearLanes();
    checkVal("flush_count", 64'(count), 64'd0);
    checkVal("flush_valid", 64'(outValid), 64'd0);
    repeat (3) tick();

    // Asynchronous reset mid-cycle with 2 entries queued.
    outReady = 1'b0;
    randLane(0, 24'h000077); randLane(1, 24'h000078);
    tick();
    clearLanes();
    #2 reset = 1'b0;
    #1;
    checkVal("arst_valid", 64'(outValid), 64'd0);
    checkVal("arst_count", 64'(count), 64'd0);
    checkVal("arst_addr", outAddr, 64'd0);
    checkVal("arst_data", outData, 64'd0);
    checkVal("arst_be", 64'(outBe), 64'd0);
    checkVal("arst_tag", 64'(outTag), 64'd0);
    checkVal("arst_in_ready", 64'(inReady), 64'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkVal("arst_rel_ready", 64'(inReady), 64'd1);
    checkVal("arst_rel_count", 64'(count), 64'd0);
    outReady = 1'b1;
    repeat (3) tick();

    // Random traffic with occasional flushes.
    for (int c = 0; c < 300; c++) begin
      clearLanes();
      for (int l = 0; l < 2; l++)
        if ($urandom_range(0, 3) != 0) randLane(l, 24'($urandom));
      outReady = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
